// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and the load unit in front of the register file.
// The load unit normally wins. After STARVE_LIMIT consecutive denied ALU cycles the
// ALU is forced through, so the ALU can never be locked out. One transfer per cycle
// drives a registered write port. Combinational hazard flags tell decode whether a
// source register still has a write that has not been accepted yet.
module regfile_wb_arbiter #(
    // Consecutive denied ALU cycles before the ALU is forced to win. Legal range is 1..7.
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,

    input  logic        lsu_valid,
    input  logic [4:0]  lsu_addr,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,

    output logic        reg_we,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,

    input  logic [4:0]  query_addr1,
    input  logic [4:0]  query_addr2,
    output logic        hazard1,
    output logic        hazard2
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]  r_starve_cnt;
    logic        r_reg_we;
    logic [4:0]  r_write_addr;
    logic [31:0] r_write_data;

    logic        w_alu_force;
    logic        w_alu_grant;
    logic        w_lsu_grant;
    logic        w_xfer;
    logic [4:0]  w_xfer_addr;
    logic [31:0] w_xfer_data;

    // The ALU is forced only while it is actually asking and has waited long enough.
    assign w_alu_force = alu_valid && (r_starve_cnt == LIMIT);

    // Grants are gated by rst, so no request is consumed while the block is in reset.
    assign w_lsu_grant = !rst && lsu_valid && !w_alu_force;
    assign w_alu_grant = !rst && alu_valid && (w_alu_force || !lsu_valid);
    assign w_xfer      = w_alu_grant || w_lsu_grant;

    assign alu_ready = w_alu_grant;
    assign lsu_ready = w_lsu_grant;

    // Select the winning requester's address and data for the output stage.
    always_comb begin
        w_xfer_addr = lsu_addr;
        w_xfer_data = lsu_data;
        if (w_alu_grant) begin
            w_xfer_addr = alu_addr;
            w_xfer_data = alu_data;
        end
    end

    // Starvation counter: counts denied ALU cycles and saturates at the limit. It clears
    // whenever the ALU is granted or has nothing to write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 3'd0;
        end else if (alu_valid && !w_alu_grant) begin
            if (r_starve_cnt != LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end else begin
            r_starve_cnt <= 3'd0;
        end
    end

    // Registered write port. Writes to x0 are accepted, but the write enable stays low.
    // Address and data hold their values in cycles with no transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_we     <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
        end else if (w_xfer) begin
            r_reg_we     <= (w_xfer_addr != 5'd0);
            r_write_addr <= w_xfer_addr;
            r_write_data <= w_xfer_data;
        end else begin
            r_reg_we     <= 1'b0;
        end
    end

    assign reg_we     = r_reg_we;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;

    // Hazard detection looks only at the pending requests. The registered output stage
    // is left out because the register file commits it on the same edge that decode
    // latches its read addresses, so that value is already visible to the read.
    logic [4:0] w_query [2];
    logic [1:0] w_hazard;

    assign w_query[0] = query_addr1;
    assign w_query[1] = query_addr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hazard
            assign w_hazard[gi] = (w_query[gi] != 5'd0) &&
                                  ((alu_valid && (alu_addr == w_query[gi])) ||
                                   (lsu_valid && (lsu_addr == w_query[gi])));
        end
    endgenerate

    assign hazard1 = w_hazard[0];
    assign hazard2 = w_hazard[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. The reference model works from the arbitration
// rules. It keeps an integer denial count, the expected write port and an expected
// register-file image.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_addr, lsu_addr;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic        reg_we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  query_addr1, query_addr2;
    logic        hazard1, hazard2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int          m_denied;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_rf [32];
    // Register file as reconstructed from the DUT write port.
    logic [31:0] s_rf [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .reg_we(reg_we), .write_addr(write_addr), .write_data(write_data),
        .query_addr1(query_addr1), .query_addr2(query_addr2),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    // Commit the DUT write port into the reconstructed register file.
    always @(posedge clk) begin
        if (reg_we === 1'b1) s_rf[write_addr] <= write_data;
    end

    // Expected grant for the current inputs, taken from the priority rules.
    task automatic predict(output logic ea, output logic el);
        ea = 1'b0;
        el = 1'b0;
        if (!rst) begin
            if (alu_valid && m_denied >= LIMIT) ea = 1'b1;
            else if (lsu_valid)                 el = 1'b1;
            else if (alu_valid)                 ea = 1'b1;
        end
    endtask

    function automatic logic exp_hazard(input logic [4:0] q);
        return (q != 5'd0) && ((alu_valid && alu_addr == q) || (lsu_valid && lsu_addr == q));
    endfunction

    // Advance the model across one rising edge, using the grants predicted for that cycle.
    task automatic model_edge(input logic ea, input logic el);
        if (rst) begin
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_denied = 0;
        end else begin
            if (ea) begin
                m_we = (alu_addr != 5'd0); m_addr = alu_addr; m_data = alu_data;
            end else if (el) begin
                m_we = (lsu_addr != 5'd0); m_addr = lsu_addr; m_data = lsu_data;
            end else begin
                m_we = 1'b0;
            end
            if ((ea || el) && m_we) m_rf[m_addr] = m_data;
            if (alu_valid && !ea) m_denied = (m_denied + 1 > LIMIT) ? LIMIT : m_denied + 1;
            else                  m_denied = 0;
        end
    endtask

    task automatic test_reset();
        logic ea, el;
        rst = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_addr = 5'd3; alu_data = 32'h1111_1111; lsu_addr = 5'd4; lsu_data = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready: alu_ready=%b lsu_ready=%b required 0 0", alu_ready, lsu_ready);
            end
            predict(ea, el);
            @(posedge clk); model_edge(ea, el); #1;
        end
        n_tests++;
        if (reg_we !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h required 0 0 0", reg_we, write_addr, write_data);
        end
        $display("[TB] reset: we=%b addr=%0d data=%h", reg_we, write_addr, write_data);
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_single_write();
        logic ea, el;
        lsu_valid = 1'b1; lsu_addr = 5'd5; lsu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: lsu_ready=%b alu_ready=%b required 1 0", lsu_ready, alu_ready);
        end
        predict(ea, el);
        @(posedge clk); model_edge(ea, el); #1;
        lsu_valid = 1'b0;
        n_tests++;
        if (reg_we !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_write: we=%b addr=%0d data=%h required 1 5 deadbeef", reg_we, write_addr, write_data);
        end
        $display("[TB] single write: addr=%0d data=%h", write_addr, write_data);
        // With no transfer, the write enable drops and the address and data hold.
        @(posedge clk); model_edge(1'b0, 1'b0); #1;
        n_tests++;
        if (reg_we !== 1'b0 || write_addr !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL idle_hold: we=%b addr=%0d data=%h required 0 5 deadbeef", reg_we, write_addr, write_data);
        end
    endtask

    task automatic test_x0();
        logic ea, el;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234_5678;
        @(negedge clk);
        n_tests++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready: alu_ready=%b required 1", alu_ready);
        end
        predict(ea, el);
        @(posedge clk); model_edge(ea, el); #1;
        alu_valid = 1'b0;
        n_tests++;
        if (reg_we !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL x0_write: we=%b addr=%0d data=%h required 0 0 12345678", reg_we, write_addr, write_data);
        end
        $display("[TB] x0 write: we=%b data=%h", reg_we, write_data);
    endtask

    task automatic test_contention();
        logic ea, el;
        logic exp_alu;
        logic [31:0] exp_d;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_addr = 5'd9; lsu_addr = 5'd10;
        alu_data = $urandom; lsu_data = $urandom;
        for (int i = 0; i < 12; i++) begin
            exp_alu = ((i % 4) == 3);
            @(negedge clk);
            n_tests++;
            if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: alu=%b lsu=%b required alu=%b lsu=%b",
                         i, alu_ready, lsu_ready, exp_alu, !exp_alu);
            end
            exp_d = exp_alu ? alu_data : lsu_data;
            predict(ea, el);
            @(posedge clk); model_edge(ea, el); #1;
            n_tests++;
            if (reg_we !== 1'b1 || write_data !== exp_d) begin
                n_fail++;
                $display("FAIL contention_write[%0d]: we=%b data=%h required 1 %h", i, reg_we, write_data, exp_d);
            end
            $display("[TB] contention %0d: grant=%s addr=%0d data=%h", i, exp_alu ? "A" : "L", write_addr, write_data);
            if (exp_alu) alu_data = $urandom; else lsu_data = $urandom;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); model_edge(1'b0, 1'b0); #1;
    endtask

    task automatic test_hazard();
        logic ea, el;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hCAFE_0007;
        query_addr1 = 5'd7; query_addr2 = 5'd3; #1;
        n_tests++;
        if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_match: h1=%b h2=%b required 1 0", hazard1, hazard2);
        end
        query_addr1 = 5'd0; #1;
        n_tests++;
        if (hazard1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_x0: h1=%b required 0", hazard1);
        end
        query_addr1 = 5'd8; query_addr2 = 5'd7; #1;
        n_tests++;
        if (hazard1 !== 1'b0 || hazard2 !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_other: h1=%b h2=%b required 0 1", hazard1, hazard2);
        end
        @(negedge clk);
        predict(ea, el);
        @(posedge clk); model_edge(ea, el); #1;
        lsu_valid = 1'b0; query_addr1 = 5'd7; #1;
        n_tests++;
        if (reg_we !== 1'b1 || write_addr !== 5'd7 || hazard1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_outstage: we=%b addr=%0d h1=%b required 1 7 0", reg_we, write_addr, hazard1);
        end
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h0;
        query_addr1 = 5'd1; query_addr2 = 5'd12; #1;
        n_tests++;
        if (hazard1 !== 1'b0 || hazard2 !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_alu: h1=%b h2=%b required 0 1", hazard1, hazard2);
        end
        $display("[TB] hazard checks done");
        @(negedge clk);
        predict(ea, el);
        @(posedge clk); model_edge(ea, el); #1;
        alu_valid = 1'b0;
    endtask

    task automatic test_midstream_reset();
        logic ea, el;
        string seq = "LLLLLLA";
        // Two LSU wins take the starvation count to 2. Then a one-cycle reset, then L, L, L, A.
        alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_addr = 5'd20; alu_data = 32'hA0A0_0020; lsu_addr = 5'd21; lsu_data = 32'hB0B0_0021;
        for (int i = 0; i < 7; i++) begin
            rst = (i == 2);
            @(negedge clk);
            n_tests++;
            if (i == 2) begin
                if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_ready: alu=%b lsu=%b required 0 0", alu_ready, lsu_ready);
                end
            end else if (alu_ready !== (seq[i] == "A") || lsu_ready !== (seq[i] == "L")) begin
                n_fail++;
                $display("FAIL midreset_grant[%0d]: alu=%b lsu=%b required %s", i, alu_ready, lsu_ready, seq.substr(i, i));
            end
            predict(ea, el);
            @(posedge clk); model_edge(ea, el); #1;
            if (i == 2) begin
                n_tests++;
                if (reg_we !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin
                    n_fail++;
                    $display("FAIL midreset_out: we=%b addr=%0d data=%h required 0 0 0", reg_we, write_addr, write_data);
                end
            end
            $display("[TB] midreset %0d: rst=%b we=%b addr=%0d", i, rst, reg_we, write_addr);
            if (ea) alu_data = $urandom;
            if (el) lsu_data = $urandom;
        end
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); model_edge(1'b0, 1'b0); #1;
    endtask

    task automatic test_random();
        logic ea, el;
        for (int i = 0; i < 400; i++) begin
            query_addr1 = 5'($urandom_range(0, 7));
            query_addr2 = 5'($urandom_range(0, 7));
            @(negedge clk);
            predict(ea, el);
            n_tests++;
            if (alu_ready !== ea || lsu_ready !== el) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: alu=%b lsu=%b required %b %b", i, alu_ready, lsu_ready, ea, el);
            end
            n_tests++;
            if (hazard1 !== exp_hazard(query_addr1) || hazard2 !== exp_hazard(query_addr2)) begin
                n_fail++;
                $display("FAIL rand_hazard[%0d]: h1=%b h2=%b required %b %b", i, hazard1, hazard2,
                         exp_hazard(query_addr1), exp_hazard(query_addr2));
            end
            @(posedge clk); model_edge(ea, el); #1;
            n_tests++;
            if (reg_we !== m_we || write_addr !== m_addr || write_data !== m_data) begin
                n_fail++;
                $display("FAIL rand_write[%0d]: we=%b addr=%0d data=%h required %b %0d %h",
                         i, reg_we, write_addr, write_data, m_we, m_addr, m_data);
            end
            $display("[TB] rand %0d: grant=%s we=%b addr=%0d data=%h", i,
                     ea ? "A" : (el ? "L" : "-"), reg_we, write_addr, write_data);
            // A requester holds its request until it is granted, then may issue a new one.
            if (!alu_valid || ea) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr  = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!lsu_valid || el) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_addr  = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); model_edge(1'b0, 1'b0); #1;
        end
        for (int r = 1; r < 32; r++) begin
            n_tests++;
            if (s_rf[r] !== m_rf[r]) begin
                n_fail++;
                $display("FAIL rand_regfile[x%0d]: got %h required %h", r, s_rf[r], m_rf[r]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_addr = 5'd0; lsu_addr = 5'd0; alu_data = 32'd0; lsu_data = 32'd0;
        query_addr1 = 5'd0; query_addr2 = 5'd0;
        m_denied = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'd0;
            s_rf[r] = 32'd0;
        end
        test_reset();
        test_single_write();
        test_x0();
        test_contention();
        test_hazard();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled only on the rising edge of clk.
REQ-002 Parameter STARVE_LIMIT, default 3, SHALL set the number of consecutive denied ALU cycles before the ALU is forced to win; legal range is 1..7.
REQ-003 clk  input  1  rising-edge clock shared with the register file.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_addr  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU writeback value.
REQ-008 alu_ready  output  1  ALU request granted this cycle.
REQ-009 lsu_valid  input  1  load-unit writeback request.
REQ-010 lsu_addr  input  5  load destination register.
REQ-011 lsu_data  input  32  load writeback value.
REQ-012 lsu_ready  output  1  LSU request granted this cycle.
REQ-013 reg_we  output  1  register-file write enable, registered.
REQ-014 write_addr  output  5  register-file write address, registered.
REQ-015 write_data  output  32  register-file write data, registered.
REQ-016 query_addr1  input  5  decode-stage source register 1.
REQ-017 query_addr2  input  5  decode-stage source register 2.
REQ-018 hazard1  output  1  query_addr1 has an unaccepted pending write.
REQ-019 hazard2  output  1  query_addr2 has an unaccepted pending write.

Function
REQ-020 A transfer SHALL occur in a cycle where valid and ready are both 1; a requester holds valid, addr and data stable until that cycle.
REQ-021 alu_ready and lsu_ready SHALL be combinational, mutually exclusive, and 0 whenever the matching valid is 0 or rst is 1.
REQ-022 An internal 3-bit starve_cnt SHALL control grants as follows:
- starve_cnt == STARVE_LIMIT and alu_valid: ALU granted.
- otherwise, lsu_valid: LSU granted.
- otherwise, alu_valid: ALU granted.
REQ-023 starve_cnt SHALL update each clock as follows:
- alu_valid and ALU not granted: increment, saturating at STARVE_LIMIT.
- ALU granted or alu_valid == 0: clear to 0.
REQ-024 Exactly one cycle after a transfer, write_addr and write_data SHALL hold the transferred addr and data.
REQ-025 reg_we SHALL be 1 in the cycle after a transfer only when the transferred addr != 0; writes to x0 are accepted but not performed.
REQ-026 In a cycle after no transfer, reg_we SHALL be 0, and write_addr and write_data hold their previous values.
REQ-027 Throughput SHALL be one write per cycle, with no bubbles between back-to-back transfers.
REQ-028 hazard1 SHALL equal (query_addr1 != 0) AND ((alu_valid AND alu_addr == query_addr1) OR (lsu_valid AND lsu_addr == query_addr1)); hazard2 is defined identically on query_addr2.
REQ-029 hazard outputs SHALL be combinational and SHALL exclude the registered output stage, because the register file commits that write on the same edge that latches read addresses.
REQ-030 Simultaneous ALU and LSU requests to the same addr SHALL be serialized in grant order, so the later grant's data is the value the register file finally holds.

Reset
REQ-031 While rst is 1 at a clock edge, the block SHALL set reg_we = 0, write_addr = 0, write_data = 0 and starve_cnt = 0.
REQ-032 During reset, alu_ready and lsu_ready SHALL be 0 regardless of valid, so no request is consumed.
REQ-033 Reset asserted mid-stream SHALL drop any in-flight output-stage write on that edge; requests still held valid are granted normally from the first cycle after rst deasserts, with LSU priority.

Verification
REQ-034 Reset test: rst = 1 for 2 cycles with both valids high -> both readies = 0 throughout; after the edge, reg_we = 0, write_addr = 0 and write_data = 0.
REQ-035 Single write test: lsu_valid with addr 5 and data 0xDEADBEEF -> lsu_ready = 1 in the same cycle; next cycle reg_we = 1, write_addr = 5, write_data = 0xDEADBEEF.
REQ-036 Contention test: both valid continuously with STARVE_LIMIT = 3 -> grant sequence L, L, L, A, L, L, L, A, ... with no idle cycles.
REQ-037 x0 test: alu_valid with addr 0 and data 0x12345678 -> alu_ready = 1; next cycle reg_we = 0.
REQ-038 Hazard test: lsu_valid with addr 7 and query_addr1 = 7 -> hazard1 = 1; query_addr1 = 0 or 8 -> hazard1 = 0; no requester valid while reg_we = 1 for addr 7 -> hazard1 = 0.
REQ-039 Mid-stream reset test: rst pulsed for 1 cycle during contention with starve_cnt = 2 -> starve_cnt = 0, first grant after reset goes to LSU, and the ALU is forced after 3 further denials.
